z80_bus_mem: RTL and testbench

Z80_BUS_MEM -- requirements
Module: z80_bus_mem

---
 rtl/z80_bus_mem.sv | 188 ++++++++++++++++++
 tb/tb_z80_bus_mem.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_mem.sv
// Z80 bus target: byte memory, I/O space, host backdoor port and a CPU write trace.
// Define Z80_BUS_MEM_WAIT_EN to build the wait-state FSM; otherwise wait_n is tied high.
module z80_bus_mem #(
  parameter int MEM_AW   = 16,
  parameter int IO_AW    = 8,
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic [7:0]        dout,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  output logic [7:0]        di,
  output logic              wait_n,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_collision,
  output logic [15:0]       wr_count,
  output logic [15:0]       last_wr_addr,
  output logic [7:0]        last_wr_data,
  output logic              last_wr_io
);

  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int IO_DEPTH  = 1 << IO_AW;

  if (MEM_WAIT < 0 || MEM_WAIT > 15 || IO_WAIT < 0 || IO_WAIT > 15) begin : g_bad_wait
    $error("z80_bus_mem: MEM_WAIT and IO_WAIT must be in 0..15");
  end

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] io  [IO_DEPTH];
  logic [7:0] mem_q;
  logic [7:0] io_q;

  logic [MEM_AW-1:0] cpu_addr;
  logic [IO_AW-1:0]  io_addr;
  logic io_act, acc, acc_d, start, wr_now;
  logic cpu_mem_we, io_we, host_hit, commit;

  // Interrupt acknowledge (iorq_n with m1_n low) is not an I/O access.
  assign cpu_addr   = A[MEM_AW-1:0];
  assign io_addr    = A[IO_AW-1:0];
  assign io_act     = !iorq_n && m1_n;
  assign acc        = (!mreq_n || io_act) && (!rd_n || !wr_n);
  assign wr_now     = (!mreq_n || io_act) && !wr_n;
  assign start      = acc && !acc_d;
  assign cpu_mem_we = !mreq_n && !wr_n;
  assign io_we      = io_act && !wr_n;
  assign host_hit   = host_we && cpu_mem_we && (host_addr == cpu_addr);

  // Tracked through reset so strobes still held after reset never look like a new start.
  always_ff @(posedge clk) begin
    acc_d <= acc;
  end

  always_ff @(posedge clk) begin
    if (host_we && !host_hit) mem[host_addr] <= host_wdata;
    if (cpu_mem_we) mem[cpu_addr] <= dout;
    if (io_we) io[io_addr] <= dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q          <= 8'h00;
      io_q           <= 8'h00;
      host_rdata     <= 8'h00;
      host_collision <= 1'b0;
    end else begin
      mem_q          <= mem[cpu_addr];
      io_q           <= io[io_addr];
      host_rdata     <= mem[host_addr];
      host_collision <= host_hit;
    end
  end

  assign di = iorq_n ? mem_q : io_q;

  logic        trk, saw_wr, lat_io;
  logic [15:0] lat_addr;
  logic [7:0]  lat_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      trk          <= 1'b0;
      saw_wr       <= 1'b0;
      lat_addr     <= 16'h0000;
      lat_data     <= 8'h00;
      lat_io       <= 1'b0;
      wr_count     <= 16'h0000;
      last_wr_addr <= 16'h0000;
      last_wr_data <= 8'h00;
      last_wr_io   <= 1'b0;
    end else begin
      if (start) trk <= 1'b1;
      else if (!acc) trk <= 1'b0;
      if (commit) saw_wr <= 1'b0;
      else if (start) saw_wr <= wr_now;
      else if (trk && wr_now) saw_wr <= 1'b1;
      // Keep overwriting so the trace reflects the final write cycle of the access.
      if ((start || trk) && wr_now) begin
        lat_addr <= A;
        lat_data <= dout;
        lat_io   <= io_act;
      end
      if (commit) begin
        wr_count     <= (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'd1;
        last_wr_addr <= lat_addr;
        last_wr_data <= lat_data;
        last_wr_io   <= lat_io;
      end
    end
  end

`ifdef Z80_BUS_MEM_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
  localparam logic [3:0] MW = 4'(MEM_WAIT);
  localparam logic [3:0] IW = 4'(IO_WAIT);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next, n_wait;

  assign n_wait = io_act ? IW : MW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (n_wait != 4'd0) begin
            cnt_next   = n_wait - 4'd1;
            state_next = S_WAIT;
          end else begin
            state_next = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        if (!acc) begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (!acc) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wait_n = (state != S_WAIT);
    commit = (state == S_HOLD) && !acc && saw_wr;
  end
`else
  logic wr_act_d;

  always_ff @(posedge clk) begin
    wr_act_d <= wr_now;
  end

  assign wait_n = 1'b1;
  assign commit = saw_wr && wr_act_d && !wr_now;
`endif

endmodule

// File: tb/tb_z80_bus_mem.sv
// Bench for z80_bus_mem: two instances (MEM_WAIT 0 and 3) driven by the same bus cycles,
// checked against a memory/trace model plus hand-computed literal values.
`timescale 1ns/1ps
module tb_z80_bus_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef Z80_BUS_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        reset;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;

  logic [7:0]  di [2];
  logic        wait_n [2];
  logic [7:0]  host_rdata [2];
  logic        host_collision [2];
  logic [15:0] wr_count [2];
  logic [15:0] last_wr_addr [2];
  logic [7:0]  last_wr_data [2];
  logic        last_wr_io [2];

  z80_bus_mem #(.MEM_AW(16), .IO_AW(8), .MEM_WAIT(0), .IO_WAIT(2)) u0 (
    .clk(clk), .reset(reset), .A(A), .dout(dout),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .di(di[0]), .wait_n(wait_n[0]),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata[0]), .host_collision(host_collision[0]),
    .wr_count(wr_count[0]), .last_wr_addr(last_wr_addr[0]),
    .last_wr_data(last_wr_data[0]), .last_wr_io(last_wr_io[0])
  );

  z80_bus_mem #(.MEM_AW(16), .IO_AW(8), .MEM_WAIT(3), .IO_WAIT(2)) u1 (
    .clk(clk), .reset(reset), .A(A), .dout(dout),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .di(di[1]), .wait_n(wait_n[1]),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata[1]), .host_collision(host_collision[1]),
    .wr_count(wr_count[1]), .last_wr_addr(last_wr_addr[1]),
    .last_wr_data(last_wr_data[1]), .last_wr_io(last_wr_io[1])
  );

  // Model state: memory images and the expected write trace.
  logic [7:0]  mdl_mem [bit [15:0]];
  logic [7:0]  mdl_io  [bit [7:0]];
  logic [15:0] exp_cnt [2];
  logic [15:0] exp_addr;
  logic [7:0]  exp_data;
  logic        exp_io;
  logic        exp_coll;
  bit          chk_en;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_wait(input int d, input bit io);
    int n;
    n = io ? 2 : ((d == 0) ? 0 : 3);
    return WAIT_EN ? n : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("wr_count%0d", d), 32'(wr_count[d]), 32'(exp_cnt[d]));
        chk($sformatf("last_wr_addr%0d", d), 32'(last_wr_addr[d]), 32'(exp_addr));
        chk($sformatf("last_wr_data%0d", d), 32'(last_wr_data[d]), 32'(exp_data));
        chk($sformatf("last_wr_io%0d", d), 32'(last_wr_io[d]), 32'(exp_io));
        chk($sformatf("host_collision%0d", d), 32'(host_collision[d]), 32'(exp_coll));
      end
    end
  end

  task automatic host_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    host_we = 1'b1; host_addr = addr; host_wdata = data;
    @(posedge clk); #1;
    host_we = 1'b0;
    mdl_mem[addr] = data;
  endtask

  task automatic host_read(input logic [15:0] addr, output logic [7:0] v0);
    @(posedge clk); #1;
    host_addr = addr;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("host_rdata%0d@%h", d, addr), 32'(host_rdata[d]), 32'(mdl_mem[addr]));
    v0 = host_rdata[0];
  endtask

  task automatic bus_access(input bit io, input bit wr, input bit m1,
                            input logic [15:0] addr, input logic [7:0] data,
                            input bit hw, input logic [15:0] haddr, input logic [7:0] hdata,
                            output logic [7:0] r0, output logic [7:0] r1);
    int lows [2];
    int falls [2];
    bit prev [2];
    bit coll;
    bit counted;
    int n;
    coll    = hw && wr && !io && (haddr == addr);
    counted = !(io && m1);
    for (int d = 0; d < 2; d++) begin lows[d] = 0; falls[d] = 0; prev[d] = 1'b1; end
    @(posedge clk); #1;
    A = addr; dout = data;
    mreq_n = io; iorq_n = !io; rd_n = wr; wr_n = !wr; m1_n = !m1;
    host_we = hw; host_addr = haddr; host_wdata = hdata;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin host_we = 1'b0; exp_coll = coll; end
      if (c == 2) exp_coll = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!wait_n[d]) begin
          lows[d]++;
          if (prev[d]) falls[d]++;
        end
        prev[d] = wait_n[d];
      end
    end
    r0 = di[0]; r1 = di[1];
    @(posedge clk); #1;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    @(posedge clk); #1;
    if (hw && !coll) mdl_mem[haddr] = hdata;
    if (wr && counted) begin
      if (io) mdl_io[addr[7:0]] = data;
      else mdl_mem[addr] = data;
      for (int d = 0; d < 2; d++)
        exp_cnt[d] = (exp_cnt[d] == 16'hFFFF) ? 16'hFFFF : exp_cnt[d] + 16'd1;
      exp_addr = addr; exp_data = data; exp_io = io;
    end
    for (int d = 0; d < 2; d++) begin
      n = counted ? exp_wait(d, io) : 0;
      chk($sformatf("wait_low_cycles%0d@%h", d, addr), 32'(lows[d]), 32'(n));
      chk($sformatf("wait_low_runs%0d@%h", d, addr), 32'(falls[d]), 32'(n > 0));
      if (!wr)
        chk($sformatf("di%0d@%h", d, addr), 32'((d == 0) ? r0 : r1),
            32'(io ? mdl_io[addr[7:0]] : mdl_mem[addr]));
    end
  endtask

  task automatic reset_mid_wait();
    int lows1;
    int late_lows;
    lows1 = 0; late_lows = 0;
    @(posedge clk); #1;
    A = 16'h3000; dout = 8'h77; mreq_n = 1'b0; wr_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!wait_n[1]) lows1++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt[0] = 16'h0000; exp_cnt[1] = 16'h0000;
    exp_addr = 16'h0000; exp_data = 8'h00; exp_io = 1'b0;
    @(negedge clk);
    chk("wait_low_before_reset1", 32'(lows1), WAIT_EN ? 32'd2 : 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("wait_n_after_reset%0d", d), 32'(wait_n[d]), 32'd1);
      chk($sformatf("di_after_reset%0d", d), 32'(di[d]), 32'h00);
      chk($sformatf("host_rdata_after_reset%0d", d), 32'(host_rdata[d]), 32'h00);
    end
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (!wait_n[d]) late_lows++;
    end
    chk("wait_low_after_reset", 32'(late_lows), 32'd0);
    @(posedge clk); #1;
    mreq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    mdl_mem[16'h3000] = 8'h77;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1, hv;
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    exp_coll = 1'b0;
    reset = 1'b1; A = 16'h0000; dout = 8'h00;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    host_we = 1'b0; host_addr = 16'h0000; host_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt[0] = 16'h0000; exp_cnt[1] = 16'h0000;
    exp_addr = 16'h0000; exp_data = 8'h00; exp_io = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_wait_n%0d", d), 32'(wait_n[d]), 32'd1);
      chk($sformatf("reset_di%0d", d), 32'(di[d]), 32'h00);
      chk($sformatf("reset_host_rdata%0d", d), 32'(host_rdata[d]), 32'h00);
    end

    // Program loaded through the backdoor, then fetched by the CPU.
    host_write(16'h0000, 8'hDD);
    host_write(16'h0001, 8'h29);
    host_write(16'h1234, 8'h3C);
    host_read(16'h0000, hv);
    chk("host_rdata_0000_literal", 32'(hv), 32'hDD);
    bus_access(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("fetch_0000_literal", 32'(r0), 32'hDD);
    bus_access(1'b0, 1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("fetch_0001_literal", 32'(r0), 32'h29);
    bus_access(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("read_1234_literal", 32'(r1), 32'h3C);

    // OUT (0x7F),A with A=0xA5 on the upper address byte, then IN from a different upper byte.
    bus_access(1'b1, 1'b1, 1'b0, 16'hA57F, 8'hA5, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("out_wr_count_literal", 32'(wr_count[0]), 32'd1);
    chk("out_last_addr_lo_literal", 32'(last_wr_addr[0][7:0]), 32'h7F);
    chk("out_last_io_literal", 32'(last_wr_io[0]), 32'd1);
    bus_access(1'b1, 1'b0, 1'b0, 16'h127F, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("in_7f_literal", 32'(r0), 32'hA5);

    // Interrupt acknowledge with wr_n low must neither write nor count.
    bus_access(1'b1, 1'b1, 1'b1, 16'h007F, 8'h5A, 1'b0, 16'h0000, 8'h00, r0, r1);
    bus_access(1'b1, 1'b0, 1'b0, 16'h007F, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);

    bus_access(1'b0, 1'b1, 1'b0, 16'h4000, 8'h99, 1'b0, 16'h0000, 8'h00, r0, r1);
    bus_access(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);

    // Same-address collision: CPU data wins; then distinct addresses both land.
    bus_access(1'b0, 1'b1, 1'b0, 16'h2000, 8'h55, 1'b1, 16'h2000, 8'hAA, r0, r1);
    host_read(16'h2000, hv);
    chk("collision_2000_literal", 32'(hv), 32'h55);
    bus_access(1'b0, 1'b1, 1'b0, 16'h2001, 8'h11, 1'b1, 16'h2002, 8'h22, r0, r1);
    host_read(16'h2001, hv);
    host_read(16'h2002, hv);
    chk("host_2002_literal", 32'(hv), 32'h22);

    reset_mid_wait();
    bus_access(1'b0, 1'b0, 1'b0, 16'h3000, 8'h00, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("after_reset_count_literal", 32'(wr_count[1]), 32'd0);

    // Saturation: preset the counter, one more write must leave it at FFFF.
    @(posedge clk); #1;
    force u0.wr_count = 16'hFFFF;
    exp_cnt[0] = 16'hFFFF;
    @(posedge clk); #1;
    release u0.wr_count;
    bus_access(1'b0, 1'b1, 1'b0, 16'h5000, 8'h42, 1'b0, 16'h0000, 8'h00, r0, r1);
    chk("saturate_literal", 32'(wr_count[0]), 32'hFFFF);
    chk("unsaturated_literal", 32'(wr_count[1]), 32'd1);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
